// File: rtl/gpio_cfg_serial_loader.sv
// Serial loader that walks the per-pad config words out to the GPIO control chain,
// farthest pad first and MSB first, then strobes serial_load so every pad latches at once.
// state | meaning: IDLE wait xfer | FETCH grab word | SHIFT_LO sclk low, data set up
// SHIFT_HI sclk high, data held | LOAD latch strobe | DONE completion pulse
module gpio_cfg_serial_loader #(
  parameter int NUM_IO  = 38,
  parameter int CFG_W   = 13,
  parameter int CLK_DIV = 2
) (
  input  logic             clock_i,
  input  logic             reset_i,
  input  logic             xfer_i,
  output logic [5:0]       cfg_raddr_o,
  input  logic [CFG_W-1:0] cfg_rdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             serial_clock_o,
  output logic             serial_data_out_o,
  output logic             serial_load_o
);

  localparam int PH_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BC_W = $clog2(CFG_W + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(CLK_DIV - 1);
  localparam logic [BC_W-1:0] BC_LAST = BC_W'(CFG_W - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_SHIFT_LO, S_SHIFT_HI, S_LOAD, S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [5:0]        raddr_q, raddr_d;
  logic [CFG_W-1:0]  shreg_q, shreg_d;
  logic [BC_W-1:0]   bit_q, bit_d;
  logic [PH_W-1:0]   ph_q, ph_d;
  logic              sdo_q, sdo_d;
  logic              phase_end;

  assign phase_end = (ph_q == PH_LAST);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      raddr_q <= '0;
      shreg_q <= '0;
      bit_q   <= '0;
      ph_q    <= '0;
      sdo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      raddr_q <= raddr_d;
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      ph_q    <= ph_d;
      sdo_q   <= sdo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    raddr_d = raddr_q;
    shreg_d = shreg_q;
    bit_d   = bit_q;
    ph_d    = '0;
    sdo_d   = sdo_q;
    case (state_q)
      S_IDLE: begin
        if (xfer_i) begin
          state_d = S_FETCH;
          raddr_d = 6'(NUM_IO - 1);
        end
      end
      S_FETCH: begin
        shreg_d = cfg_rdata_i;
        bit_d   = '0;
        sdo_d   = cfg_rdata_i[CFG_W-1];
        state_d = S_SHIFT_LO;
      end
      S_SHIFT_LO: begin
        if (phase_end) state_d = S_SHIFT_HI;
        else           ph_d = ph_q + 1'b1;
      end
      S_SHIFT_HI: begin
        if (phase_end) begin
          shreg_d = shreg_q << 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q != BC_LAST) begin
            // data only ever moves on entry to SHIFT_LO, giving a full phase of setup
            sdo_d   = shreg_d[CFG_W-1];
            state_d = S_SHIFT_LO;
          end else if (raddr_q != 6'd0) begin
            raddr_d = raddr_q - 6'd1;
            state_d = S_FETCH;
          end else begin
            sdo_d   = 1'b0;
            state_d = S_LOAD;
          end
        end else begin
          ph_d = ph_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (phase_end) state_d = S_DONE;
        else           ph_d = ph_q + 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cfg_raddr_o       = raddr_q;
  assign busy_o            = (state_q != S_IDLE);
  assign done_o            = (state_q == S_DONE);
  assign serial_clock_o    = (state_q == S_SHIFT_HI);
  assign serial_data_out_o = sdo_q;
  assign serial_load_o     = (state_q == S_LOAD);

endmodule

// File: tb/tb_gpio_cfg_serial_loader.sv
// Bench for gpio_cfg_serial_loader: a default instance and a small CLK_DIV=1 instance,
// each checked every cycle against a cycle-timetable model and a pad-chain model.
module tb_gpio_cfg_serial_loader;
  localparam int CW = 13;
  localparam int NA = 38, DA = 2;
  localparam int NB = 4,  DB = 1;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic reset_a, xfer_a, reset_b, xfer_b;
  logic [5:0] raddr_a, raddr_b;
  logic [CW-1:0] rdata_a, rdata_b;
  logic busy_a, done_a, sclk_a, sdo_a, load_a;
  logic busy_b, done_b, sclk_b, sdo_b, load_b;

  logic [CW-1:0] mem_a [64];
  logic [CW-1:0] mem_b [64];
  assign rdata_a = mem_a[raddr_a];
  assign rdata_b = mem_b[raddr_b];

  gpio_cfg_serial_loader #(.NUM_IO(NA), .CFG_W(CW), .CLK_DIV(DA)) u_a (
    .clock_i(clock), .reset_i(reset_a), .xfer_i(xfer_a),
    .cfg_raddr_o(raddr_a), .cfg_rdata_i(rdata_a),
    .busy_o(busy_a), .done_o(done_a), .serial_clock_o(sclk_a),
    .serial_data_out_o(sdo_a), .serial_load_o(load_a));

  gpio_cfg_serial_loader #(.NUM_IO(NB), .CFG_W(CW), .CLK_DIV(DB)) u_b (
    .clock_i(clock), .reset_i(reset_b), .xfer_i(xfer_b),
    .cfg_raddr_o(raddr_b), .cfg_rdata_i(rdata_b),
    .busy_o(busy_b), .done_o(done_b), .serial_clock_o(sclk_b),
    .serial_data_out_o(sdo_b), .serial_load_o(load_b));

  typedef struct {
    logic [5:0] ra;
    logic busy, done, sclk, sdo, load;
  } exp_t;

  int checks = 0, errors = 0;
  int cyc = 0;
  int start [2] = '{-1, -1};
  int edges [2] = '{0, 0};
  int lcyc  [2] = '{0, 0};
  int lpul  [2] = '{0, 0};
  int dones [2] = '{0, 0};
  int drel  [2] = '{-1, -1};
  logic prev_sclk [2] = '{1'b0, 1'b0};
  logic prev_load [2] = '{1'b0, 1'b0};
  logic [5:0] prev_ra_a = 6'd0;
  int chg_a = 0;
  logic [NA*CW-1:0] sh_a = '0;
  logic [NB*CW-1:0] sh_b = '0;
  logic [CW-1:0] lat_a [NA];
  logic [CW-1:0] lat_b [NB];

  function automatic int nio_of(int d); return (d == 0) ? NA : NB; endfunction
  function automatic int cd_of(int d);  return (d == 0) ? DA : DB; endfunction
  function automatic int per_of(int d); return 1 + 2 * cd_of(d) * CW; endfunction
  function automatic int t_of(int d);   return nio_of(d) * per_of(d) + cd_of(d) + 1; endfunction
  function automatic int rel(int d);    return (start[d] < 0) ? -1 : cyc - start[d]; endfunction
  function automatic logic [CW-1:0] word(int d, int k);
    return (d == 0) ? mem_a[k] : mem_b[k];
  endfunction

  // Where the transfer stands at relative cycle c, from the published timetable.
  function automatic exp_t model(int d, int c);
    exp_t e;
    int nio, cd, p, j, r, q;
    logic [CW-1:0] w;
    nio = nio_of(d); cd = cd_of(d); p = per_of(d);
    e.ra = 6'd0; e.sclk = 1'b0; e.sdo = 1'b0;
    if (c >= 1 && c <= nio * p) begin
      j = (c - 1) / p;
      r = (c - 1) % p;
      e.ra = 6'(nio - 1 - j);
      if (r == 0) begin
        if (j > 0) begin
          w = word(d, nio - j);
          e.sdo = w[0];
        end
      end else begin
        q = (r - 1) / cd;
        e.sclk = q[0];
        w = word(d, nio - 1 - j);
        e.sdo = w[CW - 1 - q / 2];
      end
    end
    e.busy = (c >= 1 && c <= t_of(d));
    e.done = (c == t_of(d));
    e.load = (c > nio * p && c <= nio * p + cd);
    return e;
  endfunction

  task automatic cmp(string nm, int act, int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic check_all();
    exp_t e;
    int c;
    logic [5:0] ra;
    logic bs, dn, sc, sd, ld;
    for (int d = 0; d < 2; d++) begin
      c = rel(d);
      e = model(d, c);
      if (d == 0) begin ra = raddr_a; bs = busy_a; dn = done_a; sc = sclk_a; sd = sdo_a; ld = load_a; end
      else        begin ra = raddr_b; bs = busy_b; dn = done_b; sc = sclk_b; sd = sdo_b; ld = load_b; end
      cmp((d == 0) ? "a_raddr" : "b_raddr", ra, e.ra);
      cmp((d == 0) ? "a_busy"  : "b_busy",  bs, e.busy);
      cmp((d == 0) ? "a_done"  : "b_done",  dn, e.done);
      cmp((d == 0) ? "a_sclk"  : "b_sclk",  sc, e.sclk);
      cmp((d == 0) ? "a_sdo"   : "b_sdo",   sd, e.sdo);
      cmp((d == 0) ? "a_load"  : "b_load",  ld, e.load);
      if (sc && !prev_sclk[d]) begin
        edges[d]++;
        if (d == 0) sh_a = {sh_a[NA*CW-2:0], sd};
        else        sh_b = {sh_b[NB*CW-2:0], sd};
      end
      if (ld && !prev_load[d]) begin
        lpul[d]++;
        if (d == 0) for (int k = 0; k < NA; k++) lat_a[k] = sh_a[k*CW +: CW];
        else        for (int k = 0; k < NB; k++) lat_b[k] = sh_b[k*CW +: CW];
      end
      if (ld) lcyc[d]++;
      if (dn) begin dones[d]++; drel[d] = c; end
      prev_sclk[d] = sc;
      prev_load[d] = ld;
    end
    if (raddr_a != prev_ra_a) begin
      if (rel(0) > 1) begin
        cmp("a_raddr_spacing", rel(0) - chg_a, 53);
        cmp("a_raddr_step", raddr_a, prev_ra_a - 6'd1);
      end
      chg_a = rel(0);
      prev_ra_a = raddr_a;
    end
  endtask

  task automatic tick();
    @(posedge clock);
    if (reset_a) start[0] = -1;
    else if (xfer_a && (rel(0) < 1 || rel(0) > t_of(0))) start[0] = cyc;
    if (reset_b) start[1] = -1;
    else if (xfer_b && (rel(1) < 1 || rel(1) > t_of(1))) start[1] = cyc;
    cyc++;
    @(negedge clock);
    check_all();
  endtask

  task automatic run_b_random();
    int n0, e0, k;
    for (int i = 0; i < NB; i++) mem_b[i] = CW'($urandom);
    n0 = dones[1]; e0 = edges[1];
    xfer_b = 1'b1;
    tick();
    k = 0;
    while (dones[1] == n0 && k < 200) begin
      xfer_b = ($urandom_range(0, 3) == 0);
      tick();
      k++;
    end
    xfer_b = 1'b0;
    cmp("b_rand_done_seen", dones[1] - n0, 1);
    cmp("b_rand_done_cycle", drel[1], 110);
    cmp("b_rand_edges", edges[1] - e0, 52);
    for (int i = 0; i < NB; i++) cmp("b_rand_pad", lat_b[i], mem_b[i]);
  endtask

  initial begin
    int n0, e0, l0, p0, eb0, lb0, k;
    for (int i = 0; i < NA; i++) lat_a[i] = '0;
    for (int i = 0; i < NB; i++) lat_b[i] = '0;
    for (int i = 0; i < 64; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    reset_a = 1'b1; reset_b = 1'b1; xfer_a = 1'b1; xfer_b = 1'b1;
    e0 = edges[0];
    repeat (3) tick();
    cmp("rst_busy", busy_a, 0);
    cmp("rst_sclk_edges", edges[0] - e0, 0);
    cmp("rst_raddr", raddr_a, 0);
    reset_a = 1'b0; reset_b = 1'b0; xfer_a = 1'b0; xfer_b = 1'b0;
    repeat (2) tick();

    for (int i = 0; i < NA; i++) mem_a[i] = {6'(i), 7'h5A};
    mem_b[3] = 13'h1FFF; mem_b[2] = 13'h0000; mem_b[1] = 13'h1555; mem_b[0] = 13'h0AAA;
    n0 = dones[0]; e0 = edges[0]; l0 = lcyc[0]; p0 = lpul[0];
    eb0 = edges[1]; lb0 = lcyc[1];
    xfer_a = 1'b1; xfer_b = 1'b1;
    tick();
    k = 0;
    while ((dones[0] == n0 || rel(0) < t_of(0) + 3) && k < 2100) begin
      xfer_a = (rel(0) == 100 || rel(0) == 1500);
      xfer_b = (rel(1) >= 1 && rel(1) <= t_of(1)) ? ($urandom_range(0, 2) == 0) : 1'b0;
      tick();
      k++;
    end
    xfer_a = 1'b0; xfer_b = 1'b0;
    cmp("a_done_count", dones[0] - n0, 1);
    cmp("a_done_cycle", drel[0], 2017);
    cmp("a_edges", edges[0] - e0, 494);
    cmp("a_load_width", lcyc[0] - l0, 2);
    cmp("a_load_pulses", lpul[0] - p0, 1);
    cmp("b_done_count", dones[1], 1);
    cmp("b_done_cycle", drel[1], 110);
    cmp("b_edges", edges[1] - eb0, 52);
    cmp("b_load_width", lcyc[1] - lb0, 1);
    for (int i = 0; i < NA; i++) cmp("a_pad", lat_a[i], {6'(i), 7'h5A});
    for (int i = 0; i < NB; i++) cmp("b_pad", lat_b[i], mem_b[i]);
    cmp("a_pad5_literal", lat_a[5], 13'h02DA);
    cmp("b_pad3_literal", lat_b[3], 13'h1FFF);
    cmp("b_pad1_literal", lat_b[1], 13'h1555);

    // restart after a mid-transfer reset
    p0 = lpul[0];
    xfer_a = 1'b1;
    tick();
    xfer_a = 1'b0;
    k = 0;
    while (rel(0) != 700 && k < 800) begin tick(); k++; end
    cmp("a_reached_700", rel(0), 700);
    reset_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      xfer_a = (i == 2);
      tick();
    end
    reset_a = 1'b0; xfer_a = 1'b0;
    cmp("a_busy_after_reset", busy_a, 0);
    for (int i = 0; i < NA; i++) mem_a[i] = CW'($urandom);
    repeat (5) tick();
    cmp("a_no_load_after_reset", lpul[0] - p0, 0);
    for (int i = 0; i < NA; i++) cmp("a_pad_kept", lat_a[i], {6'(i), 7'h5A});
    n0 = dones[0]; e0 = edges[0];
    xfer_a = 1'b1;
    tick();
    xfer_a = 1'b0;
    k = 0;
    while (dones[0] == n0 && k < 2100) begin tick(); k++; end
    repeat (2) tick();
    cmp("a_restart_done_seen", dones[0] - n0, 1);
    cmp("a_restart_done_cycle", drel[0], 2017);
    cmp("a_restart_edges", edges[0] - e0, 494);
    for (int i = 0; i < NA; i++) cmp("a_restart_pad", lat_a[i], mem_a[i]);

    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(0, 5)) tick();
      run_b_random();
    end
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/gpio_cfg_serial_loader.md
# gpio_cfg_serial_loader

Management-side engine that pushes the per-pad mode configuration (output enable, input/output modes, pull settings) out to the chain of user-area GPIO control blocks behind `mprj_io`. On a transfer request it reads one configuration word per pad from the housekeeping configuration register file. It shifts each word MSB-first onto a daisy-chained serial line, farthest pad first, then pulses a load strobe so every pad latches its word at once. It sits directly upstream of the pad control chain that drives the core-side GPIO out/oeb/mode signals.

## Interface
- `NUM_IO`, 38: number of pads in the chain.
- `CFG_W`, 13: configuration bits per pad.
- `CLK_DIV`, 2: core cycles per serial-clock phase (low and high); legal range ≥1.
- `clock` in 1: core clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high reset.
- `xfer` in 1: start request, sampled only in IDLE.
- `cfg_raddr` out 6: register-file read address (pad index).
- `cfg_rdata` in CFG_W: config word for `cfg_raddr`; combinational, valid in the same cycle.
- `busy` out 1: transfer in progress.
- `done` out 1: one-cycle completion pulse.
- `serial_clock` out 1: chain shift clock; receivers sample on its rising edge.
- `serial_data_out` out 1: chain data.
- `serial_load` out 1: chain latch strobe.

## Operation
- Reset values: `cfg_raddr`=0, `busy`=0, `done`=0, `serial_clock`=0, `serial_data_out`=0, `serial_load`=0; state IDLE; all counters 0.
- States: IDLE, FETCH, SHIFT_LO, SHIFT_HI, LOAD, DONE.
- IDLE: when `xfer`=1, go to FETCH with `cfg_raddr`=NUM_IO-1 and `busy`=1. `xfer` in any other state is ignored and is not queued.
- FETCH, 1 cycle: capture `cfg_rdata` into the CFG_W shift register; clear the bit counter; go to SHIFT_LO.
- SHIFT_LO, CLK_DIV cycles: `serial_clock`=0; `serial_data_out` = shift register MSB, driven from the first cycle of the phase. Then go to SHIFT_HI.
- SHIFT_HI, CLK_DIV cycles: `serial_clock`=1; data is held stable. At the end of the phase, shift left by 1 and increment the bit counter.
  - If bits sent < CFG_W: go to SHIFT_LO.
  - Else if `cfg_raddr`≠0: decrement `cfg_raddr` and go to FETCH.
  - Else: go to LOAD.
- Pad order: NUM_IO-1 down to 0. The first word shifted ends up in the farthest pad, so after NUM_IO·CFG_W rising edges pad k holds word k.
- LOAD, CLK_DIV cycles: `serial_load`=1, `serial_clock`=0, `serial_data_out`=0.
- DONE, 1 cycle: `done`=1, `busy`=1, `serial_load`=0. Next state is IDLE with `busy`=0.
- The phase counter counts 0..CLK_DIV-1. The bit counter and pad counter wrap only through the state transitions above; there is no free-running wrap.
- Reset mid-transfer: the next cycle shows reset values. No `serial_load` pulse is produced, so the pads keep their previously latched configuration. A partial shift in the chain is harmless.
- `xfer` and `reset` asserted together: reset wins.

## Timing
- Cycle 0 is the IDLE cycle in which `xfer`=1 is sampled.
- Pad j (j=0 is the first pad sent, index NUM_IO-1): FETCH at cycle 1+j·P, where P = 1+2·CLK_DIV·CFG_W.
- Bit b of pad j: `serial_clock` rises at cycle 2+j·P+(2b+1)·CLK_DIV.
- LOAD occupies cycles NUM_IO·P+1 .. NUM_IO·P+CLK_DIV.
- `done` is asserted at cycle T = NUM_IO·P+CLK_DIV+1. Defaults give T = 2017; CLK_DIV=1 gives T = 1028.
- `busy` is high for cycles 1..T.
- A new `xfer` is accepted at cycle T+1 at the earliest.
- `serial_data_out` changes only at SHIFT_LO entry, so setup and hold to the `serial_clock` rising edge are each ≥ CLK_DIV cycles.
- `cfg_raddr` changes only when FETCH is entered.

## Test plan
- Reset: hold `reset` 3 cycles with `xfer`=1 → all outputs 0, `busy`=0, no `serial_clock` edges.
- Full transfer, defaults, with `cfg_rdata` = {pad index, 7'h5A}: a bench model of a 38×13 shift chain latched on `serial_load` → each pad k reads {k,7'h5A}; `done` at cycle 2017; exactly 494 `serial_clock` rising edges; exactly one `serial_load` pulse, 2 cycles wide.
- Address sequence: `cfg_raddr` steps 37,36,…,0, one FETCH per value, 53 cycles apart.
- `xfer` pulsed at cycles 100 and 1500 of a running transfer → ignored; total `done` count is 1.
- `reset` asserted at cycle 700, then `xfer` at cycle 710 → no `serial_load` before 710; the restarted transfer delivers correct words to all pads; `done` 2017 cycles after the restart.
- CLK_DIV=1, NUM_IO=4, CFG_W=13 with words 13'h1FFF, 0, 13'h1555, 13'h0AAA at pads 3..0 → latched pad words match; `done` at cycle 4·27+2 = 110.
